// File: rtl/alu_issue_ctrl_if.sv
// Bundle between the issue controller, its requester and the external ALU.
// The controller takes the slave view; the requester/ALU side takes the master view.
interface alu_issue_ctrl_if;
    // request side
    logic        start;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    // ALU side
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_order;
    logic        alu_wea;
    logic [31:0] alu_result;
    logic        alu_overflow;
    // status / writeback side
    logic        busy;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exc_ov;
    logic        illegal;

    modport slave (
        input  start, instr, rs_val, rt_val, alu_result, alu_overflow,
        output alu_a, alu_b, alu_order, alu_wea,
        output busy, done, wb_en, wb_addr, wb_data, exc_ov, illegal
    );

    modport master (
        output start, instr, rs_val, rt_val, alu_result, alu_overflow,
        input  alu_a, alu_b, alu_order, alu_wea,
        input  busy, done, wb_en, wb_addr, wb_data, exc_ov, illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller: decodes one MIPS ALU instruction, drives the external ALU
// for a single write-enable cycle, then posts the GPR writeback and exceptions.
module alu_issue_ctrl (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;

    typedef struct packed {
        logic [3:0]  order;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dst;
        logic        ov_chk;   // signed-overflow trapping op (add/sub/addi)
    } dec_t;

    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == 6'h00) || (fn == 6'h02) || (fn == 6'h03) ||
               (fn == 6'h04) || (fn == 6'h06) || (fn == 6'h07);
    endfunction

    // Legality is decided on the live instruction so illegal ops skip the ALU.
    function automatic logic is_legal(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        logic       ok;
        op = ins[31:26];
        fn = ins[5:0];
        ok = 1'b0;
        if (op == 6'h00) begin
            if (is_shift(fn)) begin
                ok = 1'b1;
            end else begin
                case (fn)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                    6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: ok = (ins[10:6] == 5'd0);
                    default:                            ok = 1'b0;
                endcase
            end
        end else begin
            ok = (op >= 6'h08) && (op <= 6'h0F);
        end
        return ok;
    endfunction

    // Operand/order decode; only ever applied to a legal, latched instruction.
    function automatic dec_t decode(input logic [31:0] ins, input logic [31:0] rs,
                                    input logic [31:0] rt);
        dec_t        d;
        logic [31:0] sext;
        logic [31:0] zext;
        sext     = {{16{ins[15]}}, ins[15:0]};
        zext     = {16'b0, ins[15:0]};
        d.order  = 4'b0000;
        d.a      = rs;
        d.b      = rt;
        d.dst    = ins[15:11];
        d.ov_chk = 1'b0;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h00: begin d.order = 4'b1010; d.a = {27'b0, ins[10:6]}; end
                6'h02: begin d.order = 4'b1000; d.a = {27'b0, ins[10:6]}; end
                6'h03: begin d.order = 4'b1001; d.a = {27'b0, ins[10:6]}; end
                6'h04: begin d.order = 4'b1010; d.a = {27'b0, rs[4:0]}; end
                6'h06: begin d.order = 4'b1000; d.a = {27'b0, rs[4:0]}; end
                6'h07: begin d.order = 4'b1001; d.a = {27'b0, rs[4:0]}; end
                6'h20: begin d.order = 4'b0001; d.ov_chk = 1'b1; end
                6'h21: d.order = 4'b0000;
                6'h22: begin d.order = 4'b0011; d.ov_chk = 1'b1; end
                6'h23: d.order = 4'b0010;
                6'h24: d.order = 4'b0101;
                6'h25: d.order = 4'b0100;
                6'h26: d.order = 4'b0110;
                6'h27: d.order = 4'b0111;
                6'h2A: d.order = 4'b1011;
                6'h2B: d.order = 4'b1100;
                default: ;
            endcase
        end else begin
            d.dst = ins[20:16];
            d.b   = sext;
            case (ins[31:26])
                6'h08: begin d.order = 4'b0001; d.ov_chk = 1'b1; end
                6'h09: d.order = 4'b0000;
                6'h0A: d.order = 4'b1011;
                6'h0B: d.order = 4'b1100;
                6'h0C: begin d.order = 4'b0101; d.b = zext; end
                6'h0D: begin d.order = 4'b0100; d.b = zext; end
                6'h0E: begin d.order = 4'b0110; d.b = zext; end
                6'h0F: begin d.order = 4'b1010; d.a = 32'd16; d.b = zext; end
                default: ;
            endcase
        end
        return d;
    endfunction

    state_t      state, state_nxt;
    logic [31:0] instr_q, rs_q, rt_q;
    logic [31:0] a_hold, b_hold;
    logic [3:0]  order_hold;
    logic        wb_en_q, exc_q, ill_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;
    logic        accept;
    logic        legal_in;
    logic        ov_hit;
    dec_t        dec_q;

    assign accept   = (state == IDLE) && bus.start;
    assign legal_in = is_legal(bus.instr);
    assign dec_q    = decode(instr_q, rs_q, rt_q);
    assign ov_hit   = dec_q.ov_chk && bus.alu_overflow;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = legal_in ? ISSUE : DONE;
            ISSUE:   state_nxt = CHECK;
            CHECK:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are frozen at accept and stay put until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
        end else if (accept) begin
            instr_q <= bus.instr;
            rs_q    <= bus.rs_val;
            rt_q    <= bus.rt_val;
        end
    end

    // Capture the issued ALU operands so the ALU bus holds them after ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_hold     <= '0;
            b_hold     <= '0;
            order_hold <= '0;
        end else if (state == ISSUE) begin
            a_hold     <= dec_q.a;
            b_hold     <= dec_q.b;
            order_hold <= dec_q.order;
        end
    end

    // Writeback/exception registers: cleared on accept, loaded from the ALU in CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q   <= 1'b0;
            exc_q     <= 1'b0;
            ill_q     <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else if (accept) begin
            wb_en_q <= 1'b0;
            exc_q   <= 1'b0;
            ill_q   <= !legal_in;
        end else if (state == CHECK) begin
            wb_data_q <= bus.alu_result;
            wb_addr_q <= dec_q.dst;
            exc_q     <= ov_hit;
            wb_en_q   <= (dec_q.dst != 5'd0) && !ov_hit;
        end
    end

    // Outputs: pulses gated by DONE so they can never leak into other states.
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.alu_wea   = (state == ISSUE);
        bus.alu_a     = (state == ISSUE) ? dec_q.a     : a_hold;
        bus.alu_b     = (state == ISSUE) ? dec_q.b     : b_hold;
        bus.alu_order = (state == ISSUE) ? dec_q.order : order_hold;
        bus.done      = (state == DONE);
        bus.wb_en     = (state == DONE) && wb_en_q;
        bus.exc_ov    = (state == DONE) && exc_q;
        bus.illegal   = (state == DONE) && ill_q;
        bus.wb_addr   = wb_addr_q;
        bus.wb_data   = wb_data_q;
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the far side.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // External ALU: result/overflow registered on the wea edge. Overflow is
    // flagged for signed/unsigned add and sub alike, so the controller must
    // decide on its own which ops trap.
    function automatic logic [32:0] alu_model(input logic [3:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic        ov;
        r  = '0;
        ov = 1'b0;
        case (o)
            4'b0000, 4'b0001: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0010, 4'b0011: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b0100: r = a | b;
            4'b0101: r = a & b;
            4'b0110: r = a ^ b;
            4'b0111: r = ~(a | b);
            4'b1000: r = b >> a[4:0];
            4'b1001: r = $signed(b) >>> a[4:0];
            4'b1010: r = b << a[4:0];
            4'b1011: r = {31'b0, $signed(a) < $signed(b)};
            4'b1100: r = {31'b0, a < b};
            default: r = '0;
        endcase
        return {ov, r};
    endfunction

    always @(posedge clk) begin
        if (bus.alu_wea) {bus.alu_overflow, bus.alu_result} <= alu_model(bus.alu_order, bus.alu_a, bus.alu_b);
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Results captured by run_instr
    int          lat, wc;
    logic [31:0] a_s, b_s, data;
    logic [3:0]  o_s;
    logic [4:0]  addr;
    logic        en, ov, ill;

    // Pulse start for one cycle, scramble the inputs afterwards, and record what
    // the ALU bus saw and what the done cycle reported. lat=0 means no done.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        lat = 0; wc = 0; a_s = '0; b_s = '0; o_s = '0;
        en = 1'b0; addr = '0; data = '0; ov = 1'b0; ill = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.instr = ins; bus.rs_val = rs; bus.rt_val = rt;
        @(negedge clk);
        bus.start = 1'b0; bus.instr = 32'hDEADBEEF; bus.rs_val = 32'hDEADBEEF; bus.rt_val = 32'hDEADBEEF;
        for (int i = 1; i <= 8; i++) begin
            if (bus.alu_wea) begin
                wc++; a_s = bus.alu_a; b_s = bus.alu_b; o_s = bus.alu_order;
            end
            if (bus.done) begin
                lat = i; en = bus.wb_en; addr = bus.wb_addr; data = bus.wb_data;
                ov = bus.exc_ov; ill = bus.illegal;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.instr = '0; bus.rs_val = '0; bus.rt_val = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)     begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
        checks++; if (bus.alu_wea !== 1'b0)  begin errors++; $display("FAIL rst_wea: got %b want 0", bus.alu_wea); end
        checks++; if (bus.alu_a !== 32'h0)   begin errors++; $display("FAIL rst_alu_a: got %h want 0", bus.alu_a); end
        checks++; if (bus.alu_order !== 4'h0) begin errors++; $display("FAIL rst_order: got %h want 0", bus.alu_order); end
        checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL rst_wb_data: got %h want 0", bus.wb_data); end
        checks++; if (bus.wb_en !== 1'b0 || bus.illegal !== 1'b0 || bus.exc_ov !== 1'b0)
            begin errors++; $display("FAIL rst_pulses: got %b%b%b want 000", bus.wb_en, bus.illegal, bus.exc_ov); end
        rst_n = 1'b1;
    endtask

    task automatic test_addu();
        run_instr(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd5, 32'd7);
        checks++; if (lat !== 3)        begin errors++; $display("FAIL addu_lat: got %0d want 3", lat); end
        checks++; if (wc !== 1)         begin errors++; $display("FAIL addu_wea_cycles: got %0d want 1", wc); end
        checks++; if (o_s !== 4'b0000)  begin errors++; $display("FAIL addu_order: got %b want 0000", o_s); end
        checks++; if (a_s !== 32'd5 || b_s !== 32'd7) begin errors++; $display("FAIL addu_ab: got %h/%h want 5/7", a_s, b_s); end
        checks++; if (en !== 1'b1 || addr !== 5'd3) begin errors++; $display("FAIL addu_wb: got en=%b addr=%0d want 1/3", en, addr); end
        checks++; if (data !== 32'd12)  begin errors++; $display("FAIL addu_data: got %h want c", data); end
        checks++; if (ov !== 1'b0 || ill !== 1'b0) begin errors++; $display("FAIL addu_exc: got ov=%b ill=%b want 0/0", ov, ill); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.wb_en !== 1'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL addu_after: got done=%b wb_en=%b busy=%b want 000", bus.done, bus.wb_en, bus.busy); end
    endtask

    task automatic test_overflow();
        run_instr(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h20), 32'h7FFFFFFF, 32'd1);
        checks++; if (lat !== 3 || ov !== 1'b1 || en !== 1'b0)
            begin errors++; $display("FAIL add_ovf: got lat=%0d ov=%b en=%b want 3/1/0", lat, ov, en); end
        run_instr(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h22), 32'h80000000, 32'd1);
        checks++; if (lat !== 3 || ov !== 1'b1 || en !== 1'b0)
            begin errors++; $display("FAIL sub_ovf: got lat=%0d ov=%b en=%b want 3/1/0", lat, ov, en); end
        run_instr(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h21), 32'h7FFFFFFF, 32'd1);
        checks++; if (ov !== 1'b0 || en !== 1'b1 || data !== 32'h80000000)
            begin errors++; $display("FAIL addu_noovf: got ov=%b en=%b data=%h want 0/1/80000000", ov, en, data); end
        run_instr(itype(6'h08, 5'd1, 5'd6, 16'h0001), 32'h7FFFFFFF, 32'd0);
        checks++; if (ov !== 1'b1 || en !== 1'b0)
            begin errors++; $display("FAIL addi_ovf: got ov=%b en=%b want 1/0", ov, en); end
        run_instr(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h20), 32'd3, 32'd4);
        checks++; if (ov !== 1'b0 || en !== 1'b1 || data !== 32'd7 || o_s !== 4'b0001)
            begin errors++; $display("FAIL add_plain: got ov=%b en=%b data=%h order=%b want 0/1/7/0001", ov, en, data, o_s); end
    endtask

    task automatic test_shift();
        run_instr(rtype(5'd1, 5'd2, 5'd6, 5'd0, 6'h06), 32'h24, 32'h80000000);
        checks++; if (a_s !== 32'd4 || o_s !== 4'b1000 || b_s !== 32'h80000000)
            begin errors++; $display("FAIL srlv_issue: got a=%h order=%b b=%h want 4/1000/80000000", a_s, o_s, b_s); end
        checks++; if (data !== 32'h08000000 || addr !== 5'd6 || en !== 1'b1)
            begin errors++; $display("FAIL srlv_wb: got data=%h addr=%0d en=%b want 08000000/6/1", data, addr, en); end
        run_instr(rtype(5'd0, 5'd2, 5'd7, 5'd4, 6'h03), 32'hFFFFFFFF, 32'h80000000);
        checks++; if (a_s !== 32'd4 || o_s !== 4'b1001 || data !== 32'hF8000000)
            begin errors++; $display("FAIL sra_sh4: got a=%h order=%b data=%h want 4/1001/f8000000", a_s, o_s, data); end
        run_instr(rtype(5'd0, 5'd2, 5'd8, 5'd31, 6'h00), 32'd0, 32'd1);
        checks++; if (a_s !== 32'd31 || o_s !== 4'b1010 || data !== 32'h80000000)
            begin errors++; $display("FAIL sll_sh31: got a=%h order=%b data=%h want 1f/1010/80000000", a_s, o_s, data); end
    endtask

    task automatic test_itype();
        run_instr(itype(6'h0F, 5'd0, 5'd5, 16'h1234), 32'd0, 32'd0);
        checks++; if (a_s !== 32'd16 || b_s !== 32'h00001234 || o_s !== 4'b1010)
            begin errors++; $display("FAIL lui_issue: got a=%h b=%h order=%b want 10/1234/1010", a_s, b_s, o_s); end
        checks++; if (data !== 32'h12340000 || addr !== 5'd5 || en !== 1'b1)
            begin errors++; $display("FAIL lui_wb: got data=%h addr=%0d en=%b want 12340000/5/1", data, addr, en); end
        run_instr(itype(6'h09, 5'd0, 5'd0, 16'd5), 32'd0, 32'd0);
        checks++; if (lat !== 3 || en !== 1'b0 || addr !== 5'd0)
            begin errors++; $display("FAIL addiu_r0: got lat=%0d en=%b addr=%0d want 3/0/0", lat, en, addr); end
        run_instr(itype(6'h08, 5'd1, 5'd8, 16'hFFFF), 32'd10, 32'd0);
        checks++; if (b_s !== 32'hFFFFFFFF || data !== 32'd9 || addr !== 5'd8)
            begin errors++; $display("FAIL addi_sext: got b=%h data=%h addr=%0d want ffffffff/9/8", b_s, data, addr); end
        run_instr(itype(6'h0C, 5'd1, 5'd9, 16'hFFFF), 32'h12345678, 32'd0);
        checks++; if (b_s !== 32'h0000FFFF || o_s !== 4'b0101 || data !== 32'h00005678)
            begin errors++; $display("FAIL andi_zext: got b=%h order=%b data=%h want 0000ffff/0101/00005678", b_s, o_s, data); end
    endtask

    task automatic test_illegal();
        run_instr(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd5, 32'd7);
        run_instr(32'hFC000000, 32'd1, 32'd2);
        checks++; if (lat !== 1 || wc !== 0)
            begin errors++; $display("FAIL op3f_timing: got lat=%0d wea=%0d want 1/0", lat, wc); end
        checks++; if (ill !== 1'b1 || en !== 1'b0 || ov !== 1'b0)
            begin errors++; $display("FAIL op3f_flags: got ill=%b en=%b ov=%b want 1/0/0", ill, en, ov); end
        checks++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7 || bus.alu_order !== 4'b0000)
            begin errors++; $display("FAIL op3f_hold: got a=%h b=%h order=%b want 5/7/0000", bus.alu_a, bus.alu_b, bus.alu_order); end
        run_instr(rtype(5'd1, 5'd2, 5'd3, 5'd1, 6'h20), 32'd5, 32'd7);
        checks++; if (lat !== 1 || wc !== 0 || ill !== 1'b1 || en !== 1'b0)
            begin errors++; $display("FAIL add_shamt: got lat=%0d wea=%0d ill=%b en=%b want 1/0/1/0", lat, wc, ill, en); end
        @(negedge clk);
        checks++; if (bus.illegal !== 1'b0 || bus.done !== 1'b0)
            begin errors++; $display("FAIL ill_after: got ill=%b done=%b want 0/0", bus.illegal, bus.done); end
    endtask

    task automatic test_start_busy();
        int          dcount, wcount, icount;
        logic [31:0] d_data;
        dcount = 0; wcount = 0; icount = 0; d_data = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21); bus.rs_val = 32'd5; bus.rt_val = 32'd7;
        @(negedge clk);
        // keep start high with a different (illegal) instruction while busy
        bus.instr = 32'hFC000000; bus.rs_val = 32'd100; bus.rt_val = 32'd100;
        for (int i = 1; i <= 10; i++) begin
            if (bus.alu_wea) wcount++;
            if (bus.illegal) icount++;
            if (bus.done) begin dcount++; d_data = bus.wb_data; end
            if (i == 3) bus.start = 1'b0;
            @(negedge clk);
        end
        checks++; if (dcount !== 1 || wcount !== 1 || icount !== 0)
            begin errors++; $display("FAIL busy_start: got done=%0d wea=%0d ill=%0d want 1/1/0", dcount, wcount, icount); end
        checks++; if (d_data !== 32'd12)
            begin errors++; $display("FAIL busy_latch: got data=%h want c", d_data); end
    endtask

    task automatic test_back_to_back();
        run_instr(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'd1);
        checks++; if (o_s !== 4'b1011 || data !== 32'd1 || addr !== 5'd10)
            begin errors++; $display("FAIL slt: got order=%b data=%h addr=%0d want 1011/1/10", o_s, data, addr); end
        run_instr(rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h2B), 32'hFFFFFFFF, 32'd1);
        checks++; if (lat !== 3 || o_s !== 4'b1100 || data !== 32'd0)
            begin errors++; $display("FAIL sltu: got lat=%0d order=%b data=%h want 3/1100/0", lat, o_s, data); end
        run_instr(rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h27), 32'hF0F0F0F0, 32'h0F0F0000);
        checks++; if (o_s !== 4'b0111 || data !== 32'h00000F0F)
            begin errors++; $display("FAIL nor: got order=%b data=%h want 0111/00000f0f", o_s, data); end
        run_instr(rtype(5'd1, 5'd2, 5'd13, 5'd0, 6'h23), 32'h80000000, 32'd1);
        checks++; if (o_s !== 4'b0010 || data !== 32'h7FFFFFFF || en !== 1'b1 || ov !== 1'b0)
            begin errors++; $display("FAIL subu: got order=%b data=%h en=%b ov=%b want 0010/7fffffff/1/0", o_s, data, en, ov); end
    endtask

    task automatic test_reset_mid();
        int          dcount;
        int          dlat;
        logic [31:0] d_data;
        logic [4:0]  d_addr;
        dcount = 0; dlat = 0; d_data = '0; d_addr = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.instr = rtype(5'd1, 5'd2, 5'd14, 5'd0, 6'h22); bus.rs_val = 32'd9; bus.rt_val = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.alu_order !== 4'b0011)
            begin errors++; $display("FAIL mid_pre: got busy=%b order=%b want 1/0011", bus.busy, bus.alu_order); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.alu_order !== 4'h0 || bus.alu_a !== 32'h0 || bus.wb_data !== 32'h0)
            begin errors++; $display("FAIL mid_async: got busy=%b order=%b a=%h wb_data=%h want 0/0/0/0", bus.busy, bus.alu_order, bus.alu_a, bus.wb_data); end
        @(negedge clk);
        // release together with a new start: it must be taken on the very next edge
        rst_n = 1'b1;
        bus.start = 1'b1; bus.instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21); bus.rs_val = 32'd5; bus.rt_val = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1)
            begin errors++; $display("FAIL mid_accept: got busy=%b want 1", bus.busy); end
        for (int i = 1; i <= 8; i++) begin
            if (bus.done) begin
                dcount++;
                if (dlat == 0) begin dlat = i; d_data = bus.wb_data; d_addr = bus.wb_addr; end
            end
            @(negedge clk);
        end
        checks++; if (dcount !== 1 || dlat !== 3)
            begin errors++; $display("FAIL mid_done: got count=%0d lat=%0d want 1/3", dcount, dlat); end
        checks++; if (d_data !== 32'd12 || d_addr !== 5'd3)
            begin errors++; $display("FAIL mid_wb: got data=%h addr=%0d want c/3", d_data, d_addr); end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_overflow();
        test_shift();
        test_itype();
        test_illegal();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- start  in  1  request to execute instr; sampled only in IDLE
- instr  in  32  MIPS instruction word
- rs_val  in  32  GPR[rs]
- rt_val  in  32  GPR[rt]
- alu_a  out  32  to ALU rst1
- alu_b  out  32  to ALU rst2
- alu_order  out  4  to ALU order
- alu_wea  out  1  to ALU wea
- alu_result  in  32  from ALU result; registered by ALU on the wea edge
- alu_overflow  in  1  from ALU Overflow
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- wb_en  out  1  GPR write strobe; pulse coincident with done
- wb_addr  out  5  GPR write index
- wb_data  out  32  GPR write data
- exc_ov  out  1  signed-overflow pulse coincident with done
- illegal  out  1  unsupported-opcode pulse coincident with done

Function
REQ-002 The block SHALL implement an FSM with states IDLE, ISSUE, CHECK and DONE.
REQ-003 In IDLE with start=1, the block SHALL latch instr, rs_val and rt_val into internal registers and go to ISSUE, or go directly to DONE with illegal set if the instruction is unsupported.
REQ-004 start SHALL be ignored in every state other than IDLE, and the latched operands SHALL not change until the next IDLE.
REQ-005 In ISSUE, alu_wea SHALL be 1 for exactly one cycle, with alu_a, alu_b and alu_order valid that cycle; the next state SHALL be CHECK.
REQ-006 In CHECK, the block SHALL register wb_data, wb_addr, wb_en, exc_ov and done from alu_result and alu_overflow, then go to DONE.
REQ-007 In DONE, done SHALL be 1 for one cycle; the next state SHALL be IDLE.
REQ-008 Latency from the start-sampling edge to done SHALL be 3 cycles for legal instructions and 1 cycle for illegal ones.
REQ-009 Outside ISSUE, alu_wea SHALL be 0; alu_a, alu_b and alu_order SHALL hold their last values.
REQ-010 R-type (op=0) funct decode SHALL be (order, a, b): add 20h (0001,rs,rt); addu 21h (0000,rs,rt); sub 22h (0011,rs,rt); subu 23h (0010,rs,rt); and 24h (0101,rs,rt); or 25h (0100,rs,rt); xor 26h (0110,rs,rt); nor 27h (0111,rs,rt); slt 2Ah (1011,rs,rt); sltu 2Bh (1100,rs,rt).
REQ-011 R-type shifts SHALL decode as: sll 00h (1010,{27'b0,shamt},rt); srl 02h (1000,…); sra 03h (1001,…); sllv 04h (1010,{27'b0,rs_val[4:0]},rt); srlv 06h (1000,…); srav 07h (1001,…).
REQ-012 I-type decode SHALL be: addi 08h (0001,rs,sext); addiu 09h (0000,rs,sext); slti 0Ah (1011,rs,sext); sltiu 0Bh (1100,rs,sext); andi 0Ch (0101,rs,zext); ori 0Dh (0100,rs,zext); xori 0Eh (0110,rs,zext); lui 0Fh (1010,32'd16,zext).
REQ-013 sext SHALL be {{16{imm[15]}},imm}; zext SHALL be {16'b0,imm}.
REQ-014 wb_addr SHALL be rd for R-type and rt for I-type.
REQ-015 wb_en SHALL be 0 when wb_addr=0.
REQ-016 For add, sub and addi with alu_overflow=1, wb_en SHALL be 0 and exc_ov SHALL be 1.
REQ-017 Any other op/funct, including R-type with shamt≠0 on non-shift funct, SHALL be illegal: no ALU issue, wb_en=0 and illegal=1.
REQ-018 done, wb_en, exc_ov and illegal SHALL be 0 in every cycle except DONE.

Reset
REQ-019 While rst_n=0, the FSM SHALL be in IDLE and all outputs and internal registers SHALL be 0, asynchronously and including mid-operation.
REQ-020 After reset is released mid-operation, the block SHALL produce no done or wb_en pulse for the aborted instruction, and start SHALL be accepted on the first clock edge after release.

Verification
REQ-021 addu $3,$1,$2 with rs=5, rt=7 -> alu_wea=1 one cycle with order 0000; 3 cycles later wb_en=1, wb_addr=3, wb_data=12.
REQ-022 add with rs=7FFFFFFF, rt=1 -> exc_ov=1, wb_en=0, done=1; sub with 80000000-1 -> same response.
REQ-023 srlv with rs=0x24, rt=0x80000000 -> alu_a=4, wb_data=0x08000000; sra shamt=4 on 0x80000000 -> 0xF8000000.
REQ-024 lui $5,0x1234 -> alu_a=16, order 1010, wb_data=0x12340000; addiu $0,$0,5 -> done=1, wb_en=0.
REQ-025 opcode 3Fh -> illegal=1 and done=1 one cycle after start, alu_wea never asserted; start pulsed during busy -> ignored, exactly one done.
REQ-026 rst_n pulled low in CHECK -> outputs 0 immediately, no done afterwards; new start after release -> normal 3-cycle completion.
